// File: rtl/arm_mc_main_fsm.sv
// Main-control FSM for the multicycle ARM core.
// Sequences fetch/decode/execute/writeback and handshakes with variable-latency memory.
// Also provides a bus-timeout and illegal-op trap and a retired-instruction counter.
//
// Memory handshake: MemReq is high in FETCH, MEMREAD and MEMWRITE. A cycle where
// MemReq=1 and MemReady=1 completes the access. A cycle where MemReq=1 and
// MemReady=0 is a wait cycle, and the FSM holds its state. MemReady is ignored in
// every other state.
//
// dbg_state encoding: FETCH=0 DECODE=1 MEMADR=2 MEMREAD=3 MEMWRITE=4 MEMWB=5
//                     EXECR=6 EXECI=7 ALUWB=8 BRANCH=9 FAULT=10
module arm_mc_main_fsm #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       Op,
    input  logic [5:0]       Funct,
    input  logic             MemReady,
    output logic             MemReq,
    output logic             IRWrite,
    output logic             NextPC,
    output logic             RegW,
    output logic             MemW,
    output logic             Branch,
    output logic             ALUOp,
    output logic             AdrSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       Fault,
    output logic [CNT_W-1:0] RetireCnt,
    output logic [3:0]       dbg_state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWRITE = 4'd4,
        S_MEMWB    = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_FAULT    = 4'd10
    } state_t;

    // The wait counter only needs to reach TIMEOUT-1.
    localparam int unsigned WAIT_W = (TIMEOUT <= 1) ? 1 : $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] TMO_LAST = WAIT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [1:0]         fault_q, fault_d;
    logic [CNT_W-1:0]   retire_q, retire_d;

    logic mem_state;
    logic wait_cyc;
    logic timeout_hit;

    // State, wait counter, sticky fault code and retire counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
            fault_q    <= 2'b00;
            retire_q   <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            fault_q    <= fault_d;
            retire_q   <= retire_d;
        end
    end

    // Next-state, wait-counter, fault and retire logic.
    always_comb begin
        state_d    = state_q;
        fault_d    = fault_q;
        retire_d   = retire_q;
        wait_cnt_d = '0;

        mem_state   = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
        wait_cyc    = mem_state && !MemReady;
        // MemReady=1 always wins over the timeout because the timeout only fires on wait cycles.
        timeout_hit = (TIMEOUT != 0) && wait_cyc && (wait_cnt_q == TMO_LAST);

        unique case (state_q)
            S_FETCH:    if (MemReady) state_d = S_DECODE;
            S_DECODE: begin
                unique case (Op)
                    2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: begin
                        state_d = S_FAULT;
                        fault_d = 2'b10;
                    end
                endcase
            end
            S_MEMADR:   state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (MemReady) state_d = S_MEMWB;
            S_MEMWRITE: begin
                if (MemReady) begin
                    state_d  = S_FETCH;
                    retire_d = retire_q + CNT_W'(1);
                end
            end
            S_MEMWB: begin
                state_d  = S_FETCH;
                retire_d = retire_q + CNT_W'(1);
            end
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB: begin
                state_d  = S_FETCH;
                retire_d = retire_q + CNT_W'(1);
            end
            S_BRANCH: begin
                state_d  = S_FETCH;
                retire_d = retire_q + CNT_W'(1);
            end
            S_FAULT:    state_d = S_FAULT;
            default:    state_d = S_FAULT;
        endcase

        if (timeout_hit) begin
            state_d = S_FAULT;
            fault_d = 2'b01;
        end

        // Count consecutive wait cycles within one state. Clear on completion or on a state change.
        if (wait_cyc && (state_d == state_q)) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
    end

    // Moore decode of the datapath controls. IRWrite/NextPC also depend on MemReady in FETCH.
    // All controls are forced low while reset is held.
    always_comb begin
        MemReq    = 1'b0;
        IRWrite   = 1'b0;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        ALUOp     = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        if (reset) begin
            unique case (state_q)
                S_FETCH: begin
                    MemReq    = 1'b1;
                    IRWrite   = MemReady;
                    NextPC    = MemReady;
                    ALUSrcA   = 2'b01;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                end
                S_DECODE: begin
                    ALUSrcA   = 2'b01;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                end
                S_MEMADR:   ALUSrcB = 2'b01;
                S_MEMREAD: begin
                    MemReq = 1'b1;
                    AdrSrc = 1'b1;
                end
                S_MEMWRITE: begin
                    MemReq = 1'b1;
                    AdrSrc = 1'b1;
                    MemW   = 1'b1;
                end
                S_MEMWB: begin
                    ResultSrc = 2'b01;
                    RegW      = 1'b1;
                end
                S_EXECR:    ALUOp = 1'b1;
                S_EXECI: begin
                    ALUSrcB = 2'b01;
                    ALUOp   = 1'b1;
                end
                S_ALUWB:    RegW = 1'b1;
                S_BRANCH: begin
                    ALUSrcB   = 2'b01;
                    ResultSrc = 2'b10;
                    Branch    = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign Fault     = fault_q;
    assign RetireCnt = retire_q;
    assign dbg_state = state_q;

endmodule
